// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low common-anode 7-segment bus and recovers digits.
// Patterns must be stable for STABLE_CYCLES samples; a full word is emitted once every position has refreshed.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DIGITS-1:0]         anode,
  input  logic [6:0]                segmento,
  output logic [3:0]                digit_value,
  output logic [$clog2(DIGITS)-1:0] digit_index,
  output logic                      digit_valid,
  output logic                      digit_error,
  output logic [4*DIGITS-1:0]       word,
  output logic                      word_valid,
  output logic                      word_error
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int SW = DIGITS + 7;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Returns {error, value}; blank decodes to F without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0011000: r = {1'b0, 4'h9};
      7'b1111111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  logic [SW-1:0]       s_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic [DIGITS-1:0]   fresh_q, fresh_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   err_q, err_d;

  logic [3:0]          digit_value_q, digit_value_d;
  logic [IW-1:0]       digit_index_q, digit_index_d;
  logic                digit_valid_q, digit_valid_d;
  logic                digit_error_q, digit_error_d;
  logic [4*DIGITS-1:0] word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                word_error_q, word_error_d;

  logic [SW-1:0]       live_s;
  logic [DIGITS-1:0]   anode_s;
  logic                same_s, onehot_s, accept_s, word_done_s;
  logic [IW-1:0]       idx_s;
  logic [4:0]          dec_s;
  logic [DIGITS-1:0]   fresh_bit_s, fresh_next_s;

  assign live_s       = {anode, segmento};
  assign anode_s      = s_q[SW-1:7];
  assign same_s       = (live_s == s_q);
  assign onehot_s     = $onehot(~anode_s);
  assign accept_s     = (cnt_q == CNT_MAX) && armed_q && onehot_s;
  assign dec_s        = decode_seg(s_q[6:0]);
  assign fresh_bit_s  = {{(DIGITS-1){1'b0}}, 1'b1} << idx_s;
  assign fresh_next_s = fresh_q | fresh_bit_s;
  assign word_done_s  = accept_s && (idx_s == IW'(DIGITS - 1)) && (&fresh_next_s);

  // Encode the selected position; only meaningful when the anode is one-hot low.
  always_comb begin
    idx_s = {IW{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      idx_s = idx_s | (anode_s[i] ? {IW{1'b0}} : IW'(i));
    end
  end

  // Stability counter and re-arm flag; an input change always re-arms.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!same_s) begin
      cnt_d   = {CW{1'b0}};
      armed_d = 1'b1;
    end else if (accept_s) begin
      cnt_d   = cnt_q;
      armed_d = 1'b0;
    end else begin
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      armed_d = armed_q;
    end
  end

  // Slot update, word assembly and output next-state.
  always_comb begin
    val_d   = val_q;
    err_d   = err_q;
    fresh_d = fresh_q;
    if (accept_s) begin
      val_d[4*idx_s +: 4] = dec_s[3:0];
      err_d[idx_s]        = dec_s[4];
      fresh_d             = word_done_s ? {DIGITS{1'b0}} : fresh_next_s;
    end else begin
      fresh_d = fresh_q;
    end
    digit_valid_d = accept_s;
    digit_error_d = accept_s & dec_s[4];
    digit_value_d = accept_s ? dec_s[3:0] : digit_value_q;
    digit_index_d = accept_s ? idx_s : digit_index_q;
    word_valid_d  = word_done_s;
    word_d        = word_done_s ? val_d : word_q;
    word_error_d  = word_done_s ? (|err_d) : word_error_q;
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q           <= {SW{1'b1}};
      cnt_q         <= {CW{1'b0}};
      armed_q       <= 1'b1;
      fresh_q       <= {DIGITS{1'b0}};
      val_q         <= {(4*DIGITS){1'b0}};
      err_q         <= {DIGITS{1'b0}};
      digit_value_q <= 4'h0;
      digit_index_q <= {IW{1'b0}};
      digit_valid_q <= 1'b0;
      digit_error_q <= 1'b0;
      word_q        <= {(4*DIGITS){1'b0}};
      word_valid_q  <= 1'b0;
      word_error_q  <= 1'b0;
    end else begin
      s_q           <= live_s;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      fresh_q       <= fresh_d;
      val_q         <= val_d;
      err_q         <= err_d;
      digit_value_q <= digit_value_d;
      digit_index_q <= digit_index_d;
      digit_valid_q <= digit_valid_d;
      digit_error_q <= digit_error_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      word_error_q  <= word_error_d;
    end
  end

  assign digit_value = digit_value_q;
  assign digit_index = digit_index_q;
  assign digit_valid = digit_valid_q;
  assign digit_error = digit_error_q;
  assign word        = word_q;
  assign word_valid  = word_valid_q;
  assign word_error  = word_error_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4) with hand-computed expectations.
module tb_seg7_scan_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  anode = 4'hF;
  logic [6:0]  segmento = 7'h7F;
  logic [3:0]  digit_value;
  logic [1:0]  digit_index;
  logic        digit_valid, digit_error;
  logic [15:0] word;
  logic        word_valid, word_error;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int base;

  localparam logic [6:0] SEG_0 = 7'b1000000, SEG_1 = 7'b1111001, SEG_2 = 7'b0100100,
                         SEG_3 = 7'b0110000, SEG_4 = 7'b0011001, SEG_5 = 7'b0010010,
                         SEG_6 = 7'b0000010, SEG_7 = 7'b1111000, SEG_8 = 7'b0000000,
                         SEG_9 = 7'b0011000, SEG_BL = 7'b1111111, SEG_BAD = 7'b1010101;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .anode(anode), .segmento(segmento),
    .digit_value(digit_value), .digit_index(digit_index), .digit_valid(digit_valid),
    .digit_error(digit_error), .word(word), .word_valid(word_valid), .word_error(word_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (digit_valid === 1'b1) pulse_cnt++;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one position for 6 cycles; the pulse must appear exactly 5 edges after the change.
  task automatic scan_digit(input int idx, input logic [6:0] seg, input logic [3:0] ev,
                            input logic ee, input logic ewv, input logic [15:0] ew, input logic ewe);
    anode    = ~(4'b0001 << idx);
    segmento = seg;
    tick(4);
    check_value("early_valid", {31'd0, digit_valid}, 32'd0);
    tick(1);
    check_value("valid", {31'd0, digit_valid}, 32'd1);
    check_value("value", {28'd0, digit_value}, {28'd0, ev});
    check_value("index", {30'd0, digit_index}, idx);
    check_value("error", {31'd0, digit_error}, {31'd0, ee});
    check_value("word_valid", {31'd0, word_valid}, {31'd0, ewv});
    if (ewv) begin
      check_value("word", {16'd0, word}, {16'd0, ew});
      check_value("word_error", {31'd0, word_error}, {31'd0, ewe});
    end else begin
      check_value("word_hold_err", {31'd0, word_error}, {31'd0, ewe});
    end
    tick(1);
    check_value("valid_oneshot", {31'd0, digit_valid}, 32'd0);
  endtask

  initial begin
    tick(3);
    check_value("rst_value", {28'd0, digit_value}, 32'd0);
    check_value("rst_index", {30'd0, digit_index}, 32'd0);
    check_value("rst_valid", {31'd0, digit_valid}, 32'd0);
    check_value("rst_word", {16'd0, word}, 32'd0);
    check_value("rst_wvalid", {31'd0, word_valid}, 32'd0);
    check_value("rst_werr", {31'd0, word_error}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Scan "1234" in index order
    scan_digit(0, SEG_1, 4'h1, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(1, SEG_2, 4'h2, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(2, SEG_3, 4'h3, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(3, SEG_4, 4'h4, 1'b0, 1'b1, 16'h4321, 1'b0);
    check_value("word_hold", {16'd0, word}, 32'h4321);

    // Long hold is accepted once
    base = pulse_cnt;
    anode = 4'b1110; segmento = SEG_9;
    tick(50);
    check_value("hold_pulses", pulse_cnt - base, 32'd1);
    check_value("hold_value", {28'd0, digit_value}, 32'd9);
    check_value("hold_index", {30'd0, digit_index}, 32'd0);

    // Short glitch at index 2 is ignored; return is re-accepted
    scan_digit(2, SEG_3, 4'h3, 1'b0, 1'b0, 16'h0, 1'b0);
    base = pulse_cnt;
    segmento = SEG_1;
    tick(3);
    check_value("glitch_pulses", pulse_cnt - base, 32'd0);
    scan_digit(2, SEG_3, 4'h3, 1'b0, 1'b0, 16'h0, 1'b0);

    // Undecodable pattern at index 1
    scan_digit(0, SEG_5, 4'h5, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(1, SEG_BAD, 4'hE, 1'b1, 1'b0, 16'h0, 1'b0);
    scan_digit(2, SEG_7, 4'h7, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(3, SEG_8, 4'h8, 1'b0, 1'b1, 16'h87E5, 1'b1);
    scan_digit(0, SEG_0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    scan_digit(1, SEG_1, 4'h1, 1'b0, 1'b0, 16'h0, 1'b1);
    scan_digit(2, SEG_2, 4'h2, 1'b0, 1'b0, 16'h0, 1'b1);
    scan_digit(3, SEG_6, 4'h6, 1'b0, 1'b1, 16'h6210, 1'b0);

    // Illegal anode selections produce nothing; blank decodes to F
    base = pulse_cnt;
    anode = 4'b1100; segmento = SEG_1;
    tick(20);
    anode = 4'b1111;
    tick(20);
    check_value("bad_anode_pulses", pulse_cnt - base, 32'd0);
    scan_digit(3, SEG_BL, 4'hF, 1'b0, 1'b0, 16'h0, 1'b0);

    // Reset mid-word discards the partial word
    scan_digit(0, SEG_1, 4'h1, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(1, SEG_2, 4'h2, 1'b0, 1'b0, 16'h0, 1'b0);
    reset = 1'b1;
    #1;
    check_value("async_value", {28'd0, digit_value}, 32'd0);
    check_value("async_index", {30'd0, digit_index}, 32'd0);
    check_value("async_word", {16'd0, word}, 32'd0);
    tick(2);
    reset = 1'b0;
    base = pulse_cnt;
    scan_digit(2, SEG_3, 4'h3, 1'b0, 1'b0, 16'h0, 1'b0);
    scan_digit(3, SEG_4, 4'h4, 1'b0, 1'b0, 16'h0, 1'b0);
    check_value("post_rst_word", {16'd0, word}, 32'd0);
    check_value("post_rst_pulses", pulse_cnt - base, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
